// File: rtl/y8960_audio_pkg.sv
// Shared constants and types for the Y8960 cartridge audio path.
// Frame timing: one audio frame is 2**FRAME_DIV_W system clocks.
package y8960_audio_pkg;

    localparam int FRAME_DIV_W = 11;
    localparam int MCLK_BIT    = 2;
    localparam int BCLK_BIT    = 4;
    localparam int LRCLK_BIT   = 10;

    typedef logic signed [15:0] audio_sample_t;

endpackage

// File: rtl/y8960_i2s_clkgen.sv
// Free-running frame counter and registered I2S clocks (MCLK = clk/8, BCLK = clk/32, LRCLK = clk/2048).
// All three clock outputs are one-cycle-delayed copies of counter bits, so they stay mutually aligned.
module y8960_i2s_clkgen
    import y8960_audio_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    output logic [FRAME_DIV_W-1:0] cnt,
    output logic                   load,
    output logic                   mclk,
    output logic                   bclk,
    output logic                   lrclk
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            mclk  <= 1'b0;
            bclk  <= 1'b0;
            lrclk <= 1'b0;
        end else begin
            cnt   <= cnt + 1'b1;
            mclk  <= cnt[MCLK_BIT];
            bclk  <= cnt[BCLK_BIT];
            lrclk <= cnt[LRCLK_BIT];
        end
    end

    // Last cycle of the frame: shifters reload here.
    assign load = &cnt;

endmodule

// File: rtl/y8960_i2s_out.sv
// Philips-format I2S serializer driving the external DAC from the dual SSG mixer output.
// Optional attenuation (arithmetic right shift at load) is enabled by defining Y8960_I2S_ATTEN_EN.
module y8960_i2s_out
    import y8960_audio_pkg::*;
#(
    parameter int SAMPLE_W = 16
)
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] in_left,
    input  logic signed [SAMPLE_W-1:0] in_right,
    output logic                       sample_req,
`ifdef Y8960_I2S_ATTEN_EN
    input  logic [2:0]                 vol_shift,
`endif
    output logic                       audio_mclk,
    output logic                       audio_bclk,
    output logic                       audio_lrclk,
    output logic                       audio_sdata
);

    logic [FRAME_DIV_W-1:0] cnt;
    logic                   load;

    y8960_i2s_clkgen u_clkgen (
        .clk     (clk),
        .reset_n (reset_n),
        .cnt     (cnt),
        .load    (load),
        .mclk    (audio_mclk),
        .bclk    (audio_bclk),
        .lrclk   (audio_lrclk)
    );

    logic signed [SAMPLE_W-1:0] hold_l, hold_r;
    logic signed [SAMPLE_W-1:0] shift_l, shift_r;
    logic signed [SAMPLE_W-1:0] load_l, load_r;

    always_comb begin
`ifdef Y8960_I2S_ATTEN_EN
        load_l = hold_l >>> vol_shift;
        load_r = hold_r >>> vol_shift;
`else
        load_l = hold_l;
        load_r = hold_r;
`endif
    end

    // Last strobe in a frame wins; a strobe on the load cycle lands here for the next frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_l <= '0;
            hold_r <= '0;
        end else if (in_valid) begin
            hold_l <= in_left;
            hold_r <= in_right;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_l    <= '0;
            shift_r    <= '0;
            sample_req <= 1'b0;
        end else begin
            sample_req <= load;
            if (load) begin
                shift_l <= load_l;
                shift_r <= load_r;
            end
        end
    end

    logic [4:0]          slot;
    logic [SAMPLE_W-1:0] word;
    logic [SAMPLE_W-1:0] aligned;
    logic                next_bit;

    // Slot 0 is the one-BCLK Philips delay; slots past SAMPLE_W are zero padding.
    always_comb begin
        slot     = cnt[LRCLK_BIT-1:BCLK_BIT+1];
        word     = cnt[LRCLK_BIT] ? shift_r : shift_l;
        aligned  = word << (slot - 5'd1);
        next_bit = 1'b0;
        if (slot != 5'd0 && int'(slot) <= SAMPLE_W) begin
            next_bit = aligned[SAMPLE_W-1];
        end
    end

    // Updating only at slot start makes SDATA change together with the BCLK falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            audio_sdata <= 1'b0;
        end else if (cnt[BCLK_BIT:0] == '0) begin
            audio_sdata <= next_bit;
        end
    end

endmodule

// File: tb/tb_y8960_i2s_out.sv
// Self-checking bench for y8960_i2s_out: frame-level reference model, I2S decoder and clock-period probes.
// Build with Y8960_I2S_ATTEN_EN defined to exercise the attenuation path.
module tb_y8960_i2s_out;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
`ifdef Y8960_I2S_ATTEN_EN
    logic [2:0]  vol_shift = 3'd0;
`endif
    logic        sample_req, audio_mclk, audio_bclk, audio_lrclk, audio_sdata;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    y8960_i2s_out #(.SAMPLE_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_left     (in_left),
        .in_right    (in_right),
        .sample_req  (sample_req),
`ifdef Y8960_I2S_ATTEN_EN
        .vol_shift   (vol_shift),
`endif
        .audio_mclk  (audio_mclk),
        .audio_bclk  (audio_bclk),
        .audio_lrclk (audio_lrclk),
        .audio_sdata (audio_sdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m: counter value during the current cycle; fr: frame number since reset.
    int          m, fr;
    logic [15:0] hold_l, hold_r, nxt_l, nxt_r, cur_l, cur_r;
    logic        e_mclk, e_bclk, e_lrclk, e_sdata, e_req;

    function automatic logic [15:0] atten(input logic [15:0] s);
        int v;
        int sh;
        v = int'($signed(s));
`ifdef Y8960_I2S_ATTEN_EN
        sh = int'(vol_shift);
`else
        sh = 0;
`endif
        return 16'(v >>> sh);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m = 0; fr = 0;
            hold_l = '0; hold_r = '0; nxt_l = '0; nxt_r = '0; cur_l = '0; cur_r = '0;
            e_mclk = 0; e_bclk = 0; e_lrclk = 0; e_sdata = 0; e_req = 0;
        end else begin
            int p, k;
            logic [15:0] w;
            p = m;
            e_req = (m == 2047);
            if (m == 2047) begin
                nxt_l = atten(hold_l);
                nxt_r = atten(hold_r);
            end
            if (in_valid) begin
                hold_l = in_left;
                hold_r = in_right;
            end
            if (p == 0) begin
                cur_l = nxt_l;
                cur_r = nxt_r;
            end
            e_mclk  = (p / 4) % 2 == 1;
            e_bclk  = (p / 16) % 2 == 1;
            e_lrclk = p >= 1024;
            k = (p / 32) % 32;
            w = e_lrclk ? cur_r : cur_l;
            e_sdata = (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
            m = (m + 1) % 2048;
            if (m == 0) fr++;
        end
    end

    always @(negedge clk) begin
        check("mclk", audio_mclk, e_mclk);
        check("bclk", audio_bclk, e_bclk);
        check("lrclk", audio_lrclk, e_lrclk);
        check("sdata", audio_sdata, e_sdata);
        check("sample_req", sample_req, e_req);
    end

    // ---------------- I2S decoder with literal expectations ----------------
    logic [16:0] exp_q[$];
    logic        d_prev_bclk, d_prev_lr;
    logic [15:0] d_word;
    int          d_slot;

    always @(negedge clk) begin
        if (!reset_n) begin
            d_prev_bclk = 0; d_prev_lr = 1; d_word = '0; d_slot = 0;
        end else begin
            if (audio_bclk && !d_prev_bclk) begin
                d_slot = (audio_lrclk != d_prev_lr) ? 0 : d_slot + 1;
                d_prev_lr = audio_lrclk;
                if (d_slot >= 1 && d_slot <= 16) d_word = {d_word[14:0], audio_sdata};
                else check("pad_bit", audio_sdata, 0);
                if (d_slot == 31) begin
                    if (exp_q.size() == 0) check("dec_extra", {audio_lrclk, d_word}, 17'h1ffff);
                    else check("dec_word", {audio_lrclk, d_word}, exp_q.pop_front());
                    d_word = '0;
                end
            end
            d_prev_bclk = audio_bclk;
        end
    end

    // ---------------- period probes ----------------
    int   cyc = 0;
    int   last_rise[4], period[4];
    logic [3:0] prev_sig = '0;

    always @(negedge clk) begin
        logic [3:0] s;
        cyc++;
        s = {sample_req, audio_lrclk, audio_bclk, audio_mclk};
        for (int i = 0; i < 4; i++) begin
            if (!reset_n) begin
                last_rise[i] = -1; period[i] = 0;
            end else if (s[i] && !prev_sig[i]) begin
                if (last_rise[i] >= 0) period[i] = cyc - last_rise[i];
                last_rise[i] = cyc;
            end
        end
        prev_sig = s;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_phase(input int f, input int c);
        int n = 0;
        while (!(fr == f && m == c) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check("wait_phase_timeout", n >= 30000, 0);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
        exp_q.push_back({1'b0, l});
        exp_q.push_back({1'b1, r});
    endtask

    initial begin
        int n;
        // Pre-reset-pulse run: frame 0 zeros, data, repeats, coincident strobe, last-wins.
        push_frame(16'h0000, 16'h0000);
        for (int i = 0; i < 4; i++) push_frame(16'h8001, 16'h7FFE);
        push_frame(16'h1234, 16'h4321);
        push_frame(16'h00FF, 16'hFF00);
        exp_q.push_back({1'b0, 16'h00FF});
        // After the mid-frame reset.
        push_frame(16'h0000, 16'h0000);
`ifdef Y8960_I2S_ATTEN_EN
        push_frame(16'hF000, 16'h0800);
`else
        push_frame(16'h8000, 16'h4000);
`endif
        push_frame(16'h8000, 16'h4000);

        repeat (4) @(negedge clk);
        check("reset_mclk", audio_mclk, 0);
        check("reset_bclk", audio_bclk, 0);
        check("reset_lrclk", audio_lrclk, 0);
        check("reset_sdata", audio_sdata, 0);
        check("reset_req", sample_req, 0);
        @(posedge clk); #2 reset_n = 1'b1;
        @(negedge clk);

        wait_phase(0, 10);
        send(16'h8001, 16'h7FFE);

        wait_phase(2, 1500);
        check("mclk_period", period[0], 8);
        check("bclk_period", period[1], 32);
        check("lrclk_period", period[2], 2048);
        check("req_period", period[3], 2048);

        wait_phase(3, 2047);
        send(16'h1234, 16'h4321);

        wait_phase(5, 200);
        send(16'hA5A5, 16'h0001);
        wait_phase(5, 900);
        send(16'h00FF, 16'hFF00);

        wait_phase(7, 1500);
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        check("midreset_mclk", audio_mclk, 0);
        check("midreset_bclk", audio_bclk, 0);
        check("midreset_lrclk", audio_lrclk, 0);
        check("midreset_sdata", audio_sdata, 0);
        check("midreset_req", sample_req, 0);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        wait_phase(0, 10);
`ifdef Y8960_I2S_ATTEN_EN
        vol_shift = 3'd3;
`endif
        send(16'h8000, 16'h4000);
        wait_phase(1, 100);
`ifdef Y8960_I2S_ATTEN_EN
        vol_shift = 3'd0;
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check("dec_drain", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
